// File: rtl/rplybs_ctrl.sv
// rplybs_ctrl: power-up sequencer and staggered channel scheduler for the PMOS bias mirror bank.
// Optional feature macro RPLYBS_CTRL_BIAS_CHECK_EN adds BIAS_OK confirmation, bias timeout and FAULT.
module rplybs_ctrl #(
   parameter int SETTLE_CYC  = 64,
   parameter int STAGGER_CYC = 8,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       pwrup_req_i,
   input  logic       bias_ok_i,
   input  logic [5:0] ch_req_i,
   output logic       pwrup_n_o,
   output logic [5:0] ch_en_o,
   output logic       ready_o,
   output logic       fault_o,
   output logic       busy_o
);
   // state      | meaning
   // ST_OFF     | bias bank powered down, waiting for pwrup_req_i
   // ST_SETTLE  | pwrup_n low, counting out the settle time
   // ST_WAIT_OK | waiting for synchronized BIAS_OK, bounded by timeout
   // ST_RUN     | bias trusted, channel scheduler active
   // ST_FAULT   | bias never confirmed; held off until pwrup_req_i drops
   localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYC - 1);

   typedef enum logic [2:0] {
      ST_OFF,
      ST_SETTLE,
      ST_RUN
`ifdef RPLYBS_CTRL_BIAS_CHECK_EN
      , ST_WAIT_OK,
      ST_FAULT
`endif
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   settle_q, settle_d;
   logic [CW-1:0]   stag_q, stag_d;
   logic [5:0]      ch_en_q, ch_en_d;
   logic [5:0]      pend, grant;
   logic            pwrup_n_q, pwrup_n_d;
   logic            ready_q, ready_d;
   logic            busy_q, busy_d;
   logic            fault_q, fault_d;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

`ifdef RPLYBS_CTRL_BIAS_CHECK_EN
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);
   logic [CW-1:0] tmo_q, tmo_d;
   logic [1:0]    sync_q;
   logic          ok_s;
   assign ok_s = sync_q[1];
`else
   logic unused_bias_ok;
   assign unused_bias_ok = bias_ok_i;
`endif

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      stag_d   = (stag_q != '0) ? stag_q - 1'b1 : stag_q;
      pend     = ch_req_i & ~ch_en_q;
      grant    = '0;
`ifdef RPLYBS_CTRL_BIAS_CHECK_EN
      tmo_d    = tmo_q;
`endif
      case (state_q)
         ST_OFF: begin
            if (pwrup_req_i) begin
               state_d  = ST_SETTLE;
               settle_d = '0;
`ifdef RPLYBS_CTRL_BIAS_CHECK_EN
               tmo_d    = '0;
`endif
            end
         end
         ST_SETTLE: begin
            settle_d = sat_inc(settle_q);
`ifdef RPLYBS_CTRL_BIAS_CHECK_EN
            tmo_d    = sat_inc(tmo_q);
            if (settle_q == SETTLE_LAST) state_d = ST_WAIT_OK;
`else
            if (settle_q == SETTLE_LAST) state_d = ST_RUN;
`endif
         end
`ifdef RPLYBS_CTRL_BIAS_CHECK_EN
         ST_WAIT_OK: begin
            tmo_d = sat_inc(tmo_q);
            if (ok_s)                        state_d = ST_RUN;
            else if (tmo_q == TIMEOUT_LAST)  state_d = ST_FAULT;
         end
         ST_FAULT: ;
`endif
         ST_RUN: begin
            if (stag_q == '0 && pend != '0) begin
               grant  = pend & (~pend + 6'd1);  // isolate lowest pending index
               stag_d = STAGGER_LAST;
            end
         end
         default: state_d = ST_OFF;
      endcase

      if (state_q != ST_OFF && !pwrup_req_i) begin
         state_d  = ST_OFF;
         settle_d = '0;
         stag_d   = '0;
`ifdef RPLYBS_CTRL_BIAS_CHECK_EN
         tmo_d    = '0;
`endif
      end

      ch_en_d = (ch_en_q & ch_req_i) | grant;
      if (state_d != ST_RUN) ch_en_d = '0;

      ready_d   = (state_d == ST_RUN);
      pwrup_n_d = (state_d == ST_OFF);
      busy_d    = (state_d == ST_SETTLE) || (ready_d && ((ch_req_i & ~ch_en_d) != '0));
      fault_d   = 1'b0;
`ifdef RPLYBS_CTRL_BIAS_CHECK_EN
      fault_d   = (state_d == ST_FAULT);
      pwrup_n_d = pwrup_n_d || fault_d;
      busy_d    = busy_d || (state_d == ST_WAIT_OK);
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_OFF;
         settle_q  <= '0;
         stag_q    <= '0;
         ch_en_q   <= '0;
         pwrup_n_q <= 1'b1;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         fault_q   <= 1'b0;
`ifdef RPLYBS_CTRL_BIAS_CHECK_EN
         tmo_q     <= '0;
         sync_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         settle_q  <= settle_d;
         stag_q    <= stag_d;
         ch_en_q   <= ch_en_d;
         pwrup_n_q <= pwrup_n_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         fault_q   <= fault_d;
`ifdef RPLYBS_CTRL_BIAS_CHECK_EN
         tmo_q     <= tmo_d;
         sync_q    <= {sync_q[0], bias_ok_i};
`endif
      end
   end

   assign pwrup_n_o = pwrup_n_q;
   assign ch_en_o   = ch_en_q;
   assign ready_o   = ready_q;
   assign busy_o    = busy_q;
   assign fault_o   = fault_q;

endmodule

// File: tb/tb_rplybs_ctrl.sv
// tb_rplybs_ctrl: directed + random stimulus, cycle-level reference model feeding a scoreboard queue.
// Works with or without RPLYBS_CTRL_BIAS_CHECK_EN defined.
module tb_rplybs_ctrl;
   localparam int SETTLE  = 4;
   localparam int STAGGER = 8;
   localparam int TIMEOUT = 16;
`ifdef RPLYBS_CTRL_BIAS_CHECK_EN
   localparam bit BIAS_CHK = 1'b1;
`else
   localparam bit BIAS_CHK = 1'b0;
`endif
   localparam int P_OFF = 0, P_SETTLE = 1, P_WAIT = 2, P_RUN = 3, P_FAULT = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req = 1'b0;
   logic       ok  = 1'b0;
   logic [5:0] chreq = '0;
   logic       pwrup_n, ready, fault, busy;
   logic [5:0] ch_en;

   rplybs_ctrl #(
      .SETTLE_CYC (SETTLE),
      .STAGGER_CYC(STAGGER),
      .TIMEOUT_CYC(TIMEOUT)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .pwrup_req_i(req),
      .bias_ok_i  (ok),
      .ch_req_i   (chreq),
      .pwrup_n_o  (pwrup_n),
      .ch_en_o    (ch_en),
      .ready_o    (ready),
      .fault_o    (fault),
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pwrup_n;
      logic       ready;
      logic       fault;
      logic       busy;
      logic [5:0] ch_en;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passed = 0;

   // reference model state: phase plus timestamps of the events that matter
   int         phase    = P_OFF;
   int         on_cyc   = 0;
   int         last_g   = 0;
   int         last_rst = 0;
   int         cyc      = 0;
   bit         have_g   = 1'b0;
   logic [5:0] m_en     = '0;
   bit         ok_hist [0:16383];

   task automatic model_step();
      bit         ok_s;
      logic [5:0] pend;
      exp_t       e;
      if (cyc < 16384) ok_hist[cyc] = ok;
      ok_s = (cyc >= 2 && cyc - 2 > last_rst) ? ok_hist[cyc-2] : 1'b0;
      if (rst) begin
         phase = P_OFF; m_en = '0; have_g = 1'b0; last_rst = cyc;
      end else if (phase != P_OFF && !req) begin
         phase = P_OFF; m_en = '0; have_g = 1'b0;
      end else begin
         case (phase)
            P_OFF:    if (req) begin phase = P_SETTLE; on_cyc = cyc; end
            P_SETTLE: if (cyc - on_cyc == SETTLE) phase = BIAS_CHK ? P_WAIT : P_RUN;
            P_WAIT: begin
               if (ok_s) phase = P_RUN;
               else if (cyc - on_cyc == TIMEOUT) phase = P_FAULT;
            end
            P_RUN: begin
               pend = chreq & ~m_en;
               m_en = m_en & chreq;
               if (!have_g || cyc - last_g >= STAGGER) begin
                  for (int i = 0; i < 6; i++) begin
                     if (pend[i]) begin
                        m_en[i] = 1'b1; have_g = 1'b1; last_g = cyc;
                        break;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
      if (phase != P_RUN) m_en = '0;
      e.pwrup_n = (phase == P_OFF) || (phase == P_FAULT);
      e.ready   = (phase == P_RUN);
      e.fault   = (phase == P_FAULT);
      e.busy    = (phase == P_SETTLE) || (phase == P_WAIT) ||
                  ((phase == P_RUN) && ((chreq & ~m_en) != '0));
      e.ch_en   = m_en;
      exp_q.push_back(e);
      cyc++;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
   endtask

   exp_t mon_e;
   initial forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
         checks++;
         $display("FAIL scoreboard_empty cyc=%0d actual=0 entries required=1", cyc);
      end else begin
         mon_e = exp_q.pop_front();
         chk("pwrup_n", {5'b0, pwrup_n}, {5'b0, mon_e.pwrup_n});
         chk("ready",   {5'b0, ready},   {5'b0, mon_e.ready});
         chk("fault",   {5'b0, fault},   {5'b0, mon_e.fault});
         chk("busy",    {5'b0, busy},    {5'b0, mon_e.busy});
         chk("ch_en",   ch_en,           mon_e.ch_en);
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      wait_cyc(2);
      rst = 1'b0;
      // normal power-up with BIAS_OK already high
      ok = 1'b1;
      wait_cyc(3);
      req = 1'b1;
      wait_cyc(12);
      // all six channels staggered
      chreq = 6'b111111;
      wait_cyc(50);
      // power-down with every channel enabled
      req = 1'b0;
      wait_cyc(3);
      // release of bit 1 right after bit 0 is granted
      chreq = '0;
      req = 1'b1;
      wait_cyc(10);
      chreq = 6'b000111;
      wait_cyc(1);
      chreq = 6'b000101;
      wait_cyc(20);
      // bias never confirmed
      chreq = '0;
      req = 1'b0;
      wait_cyc(2);
      ok = 1'b0;
      wait_cyc(2);
      req = 1'b1;
      wait_cyc(24);
      req = 1'b0;
      wait_cyc(3);
      // reset during settle, then restart
      ok = 1'b1;
      req = 1'b1;
      wait_cyc(2);
      rst = 1'b1;
      wait_cyc(1);
      rst = 1'b0;
      wait_cyc(12);
      // random traffic
      repeat (3000) begin
         @(negedge clk);
         rst = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 39) == 0) req = ~req;
         if ($urandom_range(0, 15) == 0) ok = ~ok;
         for (int i = 0; i < 6; i++)
            if ($urandom_range(0, 11) == 0) chreq[i] = ~chreq[i];
      end
      rst = 1'b0;
      wait_cyc(3);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
